// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: single-entry instruction fetch controller.
// Requests the word at PC from instruction memory. It holds the returned word in IR
// until decode takes it, and pulses PC_enable once for each instruction it delivers.
// A Flush from decode discards the held word. If a request is still in flight, its
// answer is discarded as well.
// Optional feature: define FETCH_TIMEOUT_EN to add a fetch watchdog. After WAIT_MAX
// unacknowledged request cycles, the controller parks in ERR and raises Fetch_err.
// Only reset leaves ERR.
module inst_fetch_ctrl #(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [31:0] PC,
    output logic        PC_enable,
    input  logic        Flush,
    output logic        Mem_req,
    output logic [31:0] Mem_addr,
    input  logic        Mem_ack,
    input  logic [31:0] Mem_rdata,
    output logic [31:0] IR,
    output logic [31:0] IR_pc,
    output logic        IR_valid,
    input  logic        Dec_ready,
    output logic        Fetch_err
);

    // Elaboration-time guard on the watchdog limit
    if (WAIT_MAX < 1 || WAIT_MAX > 255) begin : gWaitMaxRange
        $error("inst_fetch_ctrl: WAIT_MAX must be in 1..255");
    end

`ifdef FETCH_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, FULL = 2'd2, ERR = 2'd3} fetchState_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, FULL = 2'd2} fetchState_t;
`endif

    fetchState_t state;
    logic        dropPending;   // next ack belongs to a flushed request

`ifdef FETCH_TIMEOUT_EN
    logic [7:0]  waitCnt;
    logic        fetchErrQ;
    localparam logic [7:0] WaitLast = 8'(WAIT_MAX - 1);
`endif

    // The request is only visible while in REQ; otherwise the port shows the held address
    assign Mem_req  = (state == REQ);
    assign Mem_addr = Mem_req ? PC : IR_pc;

`ifdef FETCH_TIMEOUT_EN
    assign Fetch_err = fetchErrQ;
`else
    assign Fetch_err = 1'b0;
`endif

    // Fetch FSM: reset beats Flush, and Flush beats ack/handshake
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state       <= IDLE;
            IR          <= '0;
            IR_pc       <= '0;
            IR_valid    <= 1'b0;
            PC_enable   <= 1'b0;
            dropPending <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            waitCnt     <= '0;
            fetchErrQ   <= 1'b0;
`endif
        end else begin
            PC_enable <= 1'b0;
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (Flush) begin
                        // If the flushed request is still outstanding, its ack must be eaten later
                        dropPending <= !Mem_ack;
`ifdef FETCH_TIMEOUT_EN
                        waitCnt     <= '0;
`endif
                    end else if (Mem_ack) begin
                        dropPending <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                        waitCnt     <= '0;
`endif
                        if (!dropPending) begin
                            IR        <= Mem_rdata;
                            IR_pc     <= PC;
                            IR_valid  <= 1'b1;
                            PC_enable <= 1'b1;
                            state     <= FULL;
                        end
                    end else begin
`ifdef FETCH_TIMEOUT_EN
                        if (waitCnt == WaitLast) begin
                            waitCnt   <= '0;
                            fetchErrQ <= 1'b1;
                            state     <= ERR;
                        end else begin
                            waitCnt <= waitCnt + 8'd1;
                        end
`endif
                    end
                end
                FULL: begin
                    if (Flush || Dec_ready) begin
                        IR_valid <= 1'b0;
                        state    <= REQ;
                    end
                end
`ifdef FETCH_TIMEOUT_EN
                ERR: state <= ERR;
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed scenarios plus a randomized run
// checked against a transaction-level model of the fetch rules.
module tb_inst_fetch_ctrl;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic [31:0] PC;
    logic        PC_enable;
    logic        Flush;
    logic        Mem_req;
    logic [31:0] Mem_addr;
    logic        Mem_ack;
    logic [31:0] Mem_rdata;
    logic [31:0] IR;
    logic [31:0] IR_pc;
    logic        IR_valid;
    logic        Dec_ready;
    logic        Fetch_err;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    inst_fetch_ctrl #(.WAIT_MAX(4)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .PC(PC), .PC_enable(PC_enable),
        .Flush(Flush), .Mem_req(Mem_req), .Mem_addr(Mem_addr), .Mem_ack(Mem_ack),
        .Mem_rdata(Mem_rdata), .IR(IR), .IR_pc(IR_pc), .IR_valid(IR_valid),
        .Dec_ready(Dec_ready), .Fetch_err(Fetch_err)
    );

    task automatic test_reset();
        Reset_n = 0; Flush = 0; Mem_ack = 0; Dec_ready = 0; PC = '0; Mem_rdata = '0;
        @(negedge Clock);
        Mem_ack = 1; Mem_rdata = 32'hFFFF_FFFF;
        @(negedge Clock);
        checks++; if (IR !== 32'h0) begin errors++; $display("FAIL reset_IR: got %h want %h", IR, 32'h0); end
        checks++; if (IR_pc !== 32'h0) begin errors++; $display("FAIL reset_IR_pc: got %h want %h", IR_pc, 32'h0); end
        checks++; if (IR_valid !== 1'b0) begin errors++; $display("FAIL reset_IR_valid: got %b want 0", IR_valid); end
        checks++; if (PC_enable !== 1'b0) begin errors++; $display("FAIL reset_PC_enable: got %b want 0", PC_enable); end
        checks++; if (Mem_req !== 1'b0) begin errors++; $display("FAIL reset_Mem_req: got %b want 0", Mem_req); end
        checks++; if (Fetch_err !== 1'b0) begin errors++; $display("FAIL reset_Fetch_err: got %b want 0", Fetch_err); end
    endtask

    task automatic test_basic();
        Reset_n = 1; PC = 32'h0; Mem_ack = 0; Dec_ready = 1;
        @(negedge Clock);
        checks++; if (Mem_req !== 1'b1) begin errors++; $display("FAIL basic_req: got %b want 1", Mem_req); end
        checks++; if (Mem_addr !== 32'h0) begin errors++; $display("FAIL basic_addr: got %h want 0", Mem_addr); end
        Mem_ack = 1; Mem_rdata = 32'h8C22_0004;
        @(negedge Clock);
        checks++; if (IR !== 32'h8C22_0004) begin errors++; $display("FAIL basic_IR: got %h want 8c220004", IR); end
        checks++; if (IR_pc !== 32'h0) begin errors++; $display("FAIL basic_IR_pc: got %h want 0", IR_pc); end
        checks++; if (IR_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", IR_valid); end
        checks++; if (PC_enable !== 1'b1) begin errors++; $display("FAIL basic_pcen: got %b want 1", PC_enable); end
        checks++; if (Mem_req !== 1'b0) begin errors++; $display("FAIL basic_req_full: got %b want 0", Mem_req); end
        Mem_ack = 0; PC = 32'h4;
        @(negedge Clock);
        #1;
        checks++; if (IR_valid !== 1'b0) begin errors++; $display("FAIL basic_hs_valid: got %b want 0", IR_valid); end
        checks++; if (PC_enable !== 1'b0) begin errors++; $display("FAIL basic_single_pulse: got %b want 0", PC_enable); end
        checks++; if (Mem_addr !== 32'h4) begin errors++; $display("FAIL basic_next_addr: got %h want 4", Mem_addr); end
    endtask

    task automatic test_delayed_ack();
        Dec_ready = 0; PC = 32'h100;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (Mem_req !== 1'b1) begin errors++; $display("FAIL delay_req[%0d]: got %b want 1", i, Mem_req); end
            checks++; if (Mem_addr !== 32'h100) begin errors++; $display("FAIL delay_addr[%0d]: got %h want 100", i, Mem_addr); end
            checks++; if (IR_valid !== 1'b0) begin errors++; $display("FAIL delay_valid[%0d]: got %b want 0", i, IR_valid); end
            Mem_ack = (i == 3); Mem_rdata = 32'hA5A5_0001;
            @(negedge Clock);
        end
        checks++; if (IR !== 32'hA5A5_0001) begin errors++; $display("FAIL delay_IR: got %h want a5a50001", IR); end
        checks++; if (IR_pc !== 32'h100) begin errors++; $display("FAIL delay_IR_pc: got %h want 100", IR_pc); end
        checks++; if (PC_enable !== 1'b1) begin errors++; $display("FAIL delay_pcen: got %b want 1", PC_enable); end
    endtask

    task automatic test_stall();
        Mem_ack = 0; Dec_ready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            checks++; if (IR !== 32'hA5A5_0001 || IR_valid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got %h/%b want a5a50001/1", i, IR, IR_valid); end
            checks++; if (Mem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d]: got %b want 0", i, Mem_req); end
            checks++; if (PC_enable !== 1'b0) begin errors++; $display("FAIL stall_pcen[%0d]: got %b want 0", i, PC_enable); end
        end
        Dec_ready = 1;
        @(negedge Clock);
        checks++; if (IR_valid !== 1'b0 || Mem_req !== 1'b1) begin errors++; $display("FAIL stall_release: got valid=%b req=%b want 0/1", IR_valid, Mem_req); end
        Dec_ready = 0;
    endtask

    task automatic test_flush();
        PC = 32'h200; Flush = 1; Mem_ack = 0;
        @(negedge Clock);
        checks++; if (Mem_req !== 1'b1) begin errors++; $display("FAIL flush_keep_req: got %b want 1", Mem_req); end
        Flush = 0; Mem_ack = 1; Mem_rdata = 32'hDEAD_BEEF;
        @(negedge Clock);
        checks++; if (IR !== 32'hA5A5_0001) begin errors++; $display("FAIL flush_drop_IR: got %h want a5a50001", IR); end
        checks++; if (IR_valid !== 1'b0 || PC_enable !== 1'b0) begin errors++; $display("FAIL flush_drop_flags: got valid=%b pcen=%b want 0/0", IR_valid, PC_enable); end
        checks++; if (Mem_req !== 1'b1) begin errors++; $display("FAIL flush_rereq: got %b want 1", Mem_req); end
        Mem_rdata = 32'h1234_5678;
        @(negedge Clock);
        checks++; if (IR !== 32'h1234_5678 || IR_pc !== 32'h200) begin errors++; $display("FAIL flush_deliver: got %h@%h want 12345678@200", IR, IR_pc); end
        checks++; if (PC_enable !== 1'b1) begin errors++; $display("FAIL flush_deliver_pcen: got %b want 1", PC_enable); end
        // flush in FULL wins over Dec_ready
        Mem_ack = 0; Flush = 1; Dec_ready = 1;
        @(negedge Clock);
        checks++; if (IR_valid !== 1'b0 || Mem_req !== 1'b1 || PC_enable !== 1'b0) begin errors++; $display("FAIL flush_full: got valid=%b req=%b pcen=%b want 0/1/0", IR_valid, Mem_req, PC_enable); end
        // flush coincident with ack
        Dec_ready = 0; Mem_ack = 1; Mem_rdata = 32'hCAFE_F00D;
        @(negedge Clock);
        checks++; if (IR !== 32'h1234_5678 || IR_valid !== 1'b0 || PC_enable !== 1'b0) begin errors++; $display("FAIL flush_ack: got %h/%b/%b want 12345678/0/0", IR, IR_valid, PC_enable); end
        Flush = 0; Mem_rdata = 32'h0BAD_C0DE;
        @(negedge Clock);
        checks++; if (IR !== 32'h0BAD_C0DE || IR_valid !== 1'b1) begin errors++; $display("FAIL flush_ack_next: got %h/%b want 0badc0de/1", IR, IR_valid); end
        Mem_ack = 0; Dec_ready = 1;
        @(negedge Clock);
        Dec_ready = 0;
    endtask

    task automatic test_reset_full();
        PC = 32'h300; Mem_ack = 1; Mem_rdata = 32'h1111_2222;
        @(negedge Clock);
        checks++; if (IR_valid !== 1'b1) begin errors++; $display("FAIL rstfull_pre: got %b want 1", IR_valid); end
        Reset_n = 0; Mem_ack = 0;
        @(negedge Clock);
        checks++; if (IR !== 32'h0 || IR_pc !== 32'h0) begin errors++; $display("FAIL rstfull_regs: got %h/%h want 0/0", IR, IR_pc); end
        checks++; if (IR_valid !== 1'b0 || PC_enable !== 1'b0 || Mem_req !== 1'b0) begin errors++; $display("FAIL rstfull_flags: got %b%b%b want 000", IR_valid, PC_enable, Mem_req); end
        Reset_n = 1; Mem_ack = 1; Mem_rdata = 32'h5555_5555;
        @(negedge Clock);
        checks++; if (IR !== 32'h0 || IR_valid !== 1'b0 || Mem_req !== 1'b1) begin errors++; $display("FAIL rstfull_late_ack: got %h/%b/%b want 0/0/1", IR, IR_valid, Mem_req); end
        Mem_rdata = 32'h3333_4444;
        @(negedge Clock);
        checks++; if (IR !== 32'h3333_4444 || IR_pc !== 32'h300) begin errors++; $display("FAIL rstfull_refetch: got %h@%h want 33334444@300", IR, IR_pc); end
        Mem_ack = 0; Dec_ready = 1;
        @(negedge Clock);
        Dec_ready = 0;
    endtask

    task automatic test_timeout();
        Reset_n = 0; Mem_ack = 0; Flush = 0; Dec_ready = 0;
        @(negedge Clock);
        Reset_n = 1;
        @(negedge Clock);
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            checks++; if (Mem_req !== 1'b1 || Fetch_err !== 1'b0) begin errors++; $display("FAIL tmo_wait[%0d]: got req=%b err=%b want 1/0", i, Mem_req, Fetch_err); end
            @(negedge Clock);
        end
        checks++; if (Fetch_err !== 1'b1 || Mem_req !== 1'b0) begin errors++; $display("FAIL tmo_err: got err=%b req=%b want 1/0", Fetch_err, Mem_req); end
        Flush = 1; Mem_ack = 1;
        repeat (3) @(negedge Clock);
        checks++; if (Fetch_err !== 1'b1 || Mem_req !== 1'b0 || IR_valid !== 1'b0 || PC_enable !== 1'b0) begin errors++; $display("FAIL tmo_sticky: got err=%b req=%b want 1/0", Fetch_err, Mem_req); end
        Flush = 0; Mem_ack = 0;
`else
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 300; i++) begin
                if (Mem_req !== 1'b1 || Fetch_err !== 1'b0) bad++;
                @(negedge Clock);
            end
            checks++; if (bad !== 0) begin errors++; $display("FAIL tmo_wait_forever: got %0d bad cycles want 0", bad); end
        end
`endif
        Reset_n = 0;
        @(negedge Clock);
        checks++; if (Fetch_err !== 1'b0) begin errors++; $display("FAIL tmo_reset_clear: got %b want 0", Fetch_err); end
    endtask

    // Transaction-level model: an ack that is seen while a fetch is outstanding delivers
    // unless that request window saw a Flush (or the ack itself coincides with one).
    // A delivered word stays visible until a flush or a handshake.
    task automatic test_random();
        bit          expValid, expPcEn, poisoned, accepted;
        logic [31:0] expIr, expPc, pcModel;
        int          noAckRun;
        expValid = 0; expPcEn = 0; poisoned = 0; noAckRun = 0;
        expIr = '0; expPc = '0;
        pcModel = $urandom & 32'hFFFF_FFFC;
        Reset_n = 0; Flush = 0; Mem_ack = 0; Dec_ready = 0; PC = pcModel;
        @(negedge Clock);
        Reset_n = 1;
        @(negedge Clock);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            checks++; if (IR_valid !== expValid) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, IR_valid, expValid); end
            if (expValid) begin
                checks++; if (IR !== expIr || IR_pc !== expPc) begin errors++; $display("FAIL rnd_IR@%0d: got %h@%h want %h@%h", cyc, IR, IR_pc, expIr, expPc); end
            end
            checks++; if (PC_enable !== expPcEn) begin errors++; $display("FAIL rnd_pcen@%0d: got %b want %b", cyc, PC_enable, expPcEn); end
            checks++; if (Mem_req !== !expValid || Fetch_err !== 1'b0) begin errors++; $display("FAIL rnd_req@%0d: got req=%b err=%b want %b/0", cyc, Mem_req, Fetch_err, !expValid); end
            if (expPcEn) pcModel = pcModel + 32'd4;
            Flush = ($urandom_range(0, 9) == 0);
            if (Flush) pcModel = $urandom;
            PC = pcModel;
            Dec_ready = $urandom_range(0, 1);
            Mem_rdata = $urandom;
            if (!expValid) Mem_ack = (noAckRun >= 2) ? 1'b1 : ($urandom_range(0, 2) == 0);
            else           Mem_ack = ($urandom_range(0, 3) == 0);
            #1;
            checks++; if (Mem_addr !== (expValid ? expPc : PC)) begin errors++; $display("FAIL rnd_addr@%0d: got %h want %h", cyc, Mem_addr, expValid ? expPc : PC); end
            accepted = !expValid && Mem_ack && !Flush && !poisoned;
            if (!expValid) begin
                if (Mem_ack) begin poisoned = 0; noAckRun = 0; end
                else begin noAckRun++; if (Flush) poisoned = 1; end
            end
            if (accepted) begin expIr = Mem_rdata; expPc = PC; end
            expValid = accepted || (expValid && !Flush && !Dec_ready);
            expPcEn  = accepted;
            @(negedge Clock);
        end
        Flush = 0; Mem_ack = 0; Dec_ready = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_delayed_ack();
        test_stall();
        test_flush();
        test_reset_full();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 255, SHALL set the number of REQ cycles without Mem_ack before timeout; range 1..255; used only with FETCH_TIMEOUT_EN.
REQ-002 Clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Reset_n  input  1  SHALL be a synchronous, active-low reset.
REQ-004 PC  input  32  SHALL carry the current instruction address from the address generator.
REQ-005 PC_enable  output  1  SHALL pulse to advance the address generator's PC.
REQ-006 Flush  input  1  SHALL signal a redirect from decode: discard the held instruction and any in-flight fetch.
REQ-007 Mem_req  output  1  SHALL be the instruction-memory read request, level-held until acknowledged.
REQ-008 Mem_addr  output  32  SHALL be the instruction-memory read address.
REQ-009 Mem_ack  input  1  SHALL flag Mem_rdata valid; it is sampled only while Mem_req=1.
REQ-010 Mem_rdata  input  32  SHALL be the instruction word returned by memory.
REQ-011 IR  output  32  SHALL be the fetched instruction register.
REQ-012 IR_pc  output  32  SHALL be the address IR was fetched from.
REQ-013 IR_valid  output  1  SHALL flag IR/IR_pc valid to decode.
REQ-014 Dec_ready  input  1  SHALL flag that decode accepts IR this cycle.
REQ-015 Fetch_err  output  1  SHALL be the sticky fetch-timeout flag.

Function
REQ-016 The FSM SHALL use states IDLE, REQ, FULL and ERR; ERR SHALL exist only with FETCH_TIMEOUT_EN.
REQ-017 IDLE SHALL go to REQ on the first clock edge with Reset_n=1.
REQ-018 In REQ, Mem_req=1 and Mem_addr=PC (combinational); elsewhere Mem_req=0 and Mem_addr=IR_pc.
REQ-019 REQ with Mem_ack=1, Flush=0, no drop pending SHALL load IR<=Mem_rdata, IR_pc<=PC, IR_valid<=1 and go to FULL.
REQ-020 PC_enable SHALL be 1 for exactly the first cycle in FULL, giving exactly one PC advance per delivered instruction.
REQ-021 Minimum latency: ack in the first REQ cycle SHALL give IR_valid=1 on the next cycle.
REQ-022 FULL SHALL hold IR, IR_pc and IR_valid stable until IR_valid & Dec_ready is sampled, then clear IR_valid and go to REQ.
REQ-023 A handshake in the first FULL cycle SHALL be legal; the next REQ then presents the already-advanced PC.
REQ-024 Flush in FULL SHALL clear IR_valid and go to REQ; Flush SHALL win over Dec_ready, with no handshake counted.
REQ-025 Flush in REQ without Mem_ack SHALL keep Mem_req high and set a drop flag; the next ack SHALL be discarded and the drop flag cleared, the FSM SHALL stay in REQ, and a fresh request SHALL follow.
REQ-026 Flush in REQ coincident with Mem_ack SHALL discard the data: no IR load, no PC_enable, stay in REQ.
REQ-027 Priority SHALL be Reset_n=0 > Flush > Mem_ack / Dec_ready.
REQ-028 IR_pc SHALL be a full 32-bit copy; no alignment check or masking SHALL be applied.

Reset
REQ-029 Reset_n=0 at a rising edge SHALL force IDLE and IR=0, IR_pc=0, IR_valid=0, PC_enable=0, Mem_req=0, Fetch_err=0, and clear the drop flag and timeout counter.
REQ-030 Reset mid-fetch SHALL drop Mem_req the next cycle; a late Mem_ack SHALL be ignored because Mem_req=0.

Configuration
REQ-031 With FETCH_TIMEOUT_EN defined, an 8-bit counter SHALL increment each REQ cycle without ack.
REQ-032 The counter SHALL clear on ack, Flush or leaving REQ.
REQ-033 On reaching WAIT_MAX, the FSM SHALL enter ERR: Fetch_err=1, Mem_req=0, IR_valid=0 and PC_enable=0, held until reset; Flush SHALL NOT exit ERR.
REQ-034 Without FETCH_TIMEOUT_EN, there SHALL be no counter and no ERR state, Fetch_err SHALL be tied 0, and REQ SHALL wait indefinitely.

Verification
REQ-035 Reset release, PC=0x0, Mem_ack in first REQ cycle, Mem_rdata=0x8C220004, Dec_ready=1 -> IR=0x8C220004, IR_pc=0x0, IR_valid one cycle later, single PC_enable pulse.
REQ-036 Mem_ack delayed 3 cycles -> Mem_req high and Mem_addr stable for 4 cycles, then IR loads; exactly one PC_enable.
REQ-037 Dec_ready=0 for 5 cycles in FULL -> IR/IR_valid held, no new Mem_req, PC_enable high only in the first FULL cycle.
REQ-038 Flush in REQ 1 cycle before ack, then ack with 0xDEADBEEF -> IR unchanged, no PC_enable, second Mem_req issued, next ack data delivered.
REQ-039 FETCH_TIMEOUT_EN, WAIT_MAX=4, Mem_ack never -> Fetch_err=1 after 4 REQ cycles, Mem_req=0, stays until Reset_n=0; without the macro, Mem_req stays high for 300 cycles and Fetch_err=0.
REQ-040 Reset_n=0 in FULL with IR_valid=1 -> all outputs at reset values next cycle; refetch starts after release.
